flash_session_ctrl: RTL

Top-level sequencer for one JPEG file write to flash. It opens a session and launches the header writer. It waits for the header to drain, then releases the data writer to stream entropy-coded words. It closes the session on end-of-file. It sits above the header/data writer pair and drives the flash master command lines and the data-writer enable.

---
 rtl/flash_pkg.sv | 39 +++
 rtl/flash_session_ctrl_if.sv | 33 +++
 rtl/flash_sess_wdog.sv | 32 +++
 rtl/flash_session_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared encodings for the JPEG flash session sequencer: master commands,
// session states and the default header-timeout depth.
package flash_pkg;

   localparam int DEF_HDR_TIMEOUT = 4096;

   typedef enum logic [1:0] {
      CMD_IDLE  = 2'b00,
      CMD_OPEN  = 2'b01,
      CMD_WRITE = 2'b10,
      CMD_CLOSE = 2'b11
   } cmd_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_DIM,
      S_HDR_START,
      S_HDR_RUN,
      S_DATA,
      S_CLOSE,
      S_DONE,
      S_ERR
   } state_t;

   function automatic cmd_t cmd_for(input state_t s);
      case (s)
         S_WAIT_DIM:                   return CMD_OPEN;
         S_HDR_START, S_HDR_RUN, S_DATA: return CMD_WRITE;
         S_CLOSE:                      return CMD_CLOSE;
         default:                      return CMD_IDLE;
      endcase
   endfunction

   // Idle-like states are the only ones that accept a new session request.
   function automatic logic is_session(input state_t s);
      return !(s == S_IDLE || s == S_DONE || s == S_ERR);
   endfunction

endpackage

// File: rtl/flash_session_ctrl_if.sv
// Session-level signals between the sequencer, the header/data writer pair
// and the flash master. master = the sequencer, slave = its surroundings.
interface flash_session_ctrl_if
   import flash_pkg::*;
#(
   parameter int CNT_W = 32
);

   logic             go;
   logic             dimensions_valid;
   logic             hdr_busy;
   logic             d_write;
   logic             eof_in;
   logic             s_halt;
   logic             hdr_start;
   logic             data_en;
   logic             session_busy;
   logic             done;
   logic             error;
   cmd_t             m_cmd;
   logic [CNT_W-1:0] word_count;

   modport master (
      input  go, dimensions_valid, hdr_busy, d_write, eof_in, s_halt,
      output hdr_start, data_en, session_busy, done, error, m_cmd, word_count
   );

   modport slave (
      output go, dimensions_valid, hdr_busy, d_write, eof_in, s_halt,
      input  hdr_start, data_en, session_busy, done, error, m_cmd, word_count
   );

endinterface

// File: rtl/flash_sess_wdog.sv
// Header-phase watchdog: counts enabled cycles since clear and flags the
// cycle on which the count would reach LIMIT.
module flash_sess_wdog
   import flash_pkg::*;
#(
   parameter int LIMIT = DEF_HDR_TIMEOUT
) (
   input  logic clk_in,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && count != CW'(LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   // Fires on the LIMIT-th enabled cycle, so the owner leaves on that edge.
   assign expire = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/flash_session_ctrl.sv
// Sequencer for one JPEG file write to flash: open, header, data, close.
// Optional header timeout enabled by defining FLASH_SESSION_TIMEOUT_EN.
module flash_session_ctrl
   import flash_pkg::*;
#(
   parameter int HDR_TIMEOUT = DEF_HDR_TIMEOUT,
   parameter int CNT_W       = 32
) (
   input logic                  clk_in,
   input logic                  rst,
   flash_session_ctrl_if.master bus
);

`ifdef FLASH_SESSION_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   if (HDR_TIMEOUT < 1) begin : g_bad_timeout
      $error("HDR_TIMEOUT must be at least 1");
   end

   state_t           state, state_next;
   logic             hdr_seen;
   logic             expire;
   logic             go_ok;
   logic             count_en;
   logic [CNT_W-1:0] word_count;

   cmd_t m_cmd_q, cmd_next;
   logic hdr_start_q, hdr_start_next;
   logic data_en_q, data_en_next;
   logic busy_q, busy_next;
   logic done_q, done_next;
   logic err_q, err_next;

   assign go_ok    = bus.go && !is_session(state);
   assign count_en = (state == S_DATA) && bus.d_write && !bus.s_halt;

`ifdef FLASH_SESSION_TIMEOUT_EN
   flash_sess_wdog #(
      .LIMIT(HDR_TIMEOUT)
   ) u_wdog (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (state != S_HDR_RUN),
      .en     ((state == S_HDR_RUN) && !hdr_seen),
      .expire (expire)
   );
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      // NOTE: defaults first, so no branch of the case can infer a latch.
      state_next = state;
      case (state)
         S_IDLE:      if (bus.go) state_next = S_WAIT_DIM;
         S_WAIT_DIM:  if (bus.dimensions_valid) state_next = S_HDR_START;
         S_HDR_START: state_next = S_HDR_RUN;
         S_HDR_RUN: begin
            // A header beat on the expiry cycle outranks the timeout.
            if (!bus.hdr_busy) begin
               if (hdr_seen)    state_next = S_DATA;
               else if (expire) state_next = S_ERR;
            end
         end
         S_DATA:      if (bus.eof_in) state_next = S_CLOSE;
         S_CLOSE:     if (!bus.s_halt) state_next = S_DONE;
         S_DONE:      state_next = bus.go ? S_WAIT_DIM : S_IDLE;
         S_ERR:       if (bus.go) state_next = S_WAIT_DIM;
         default:     state_next = S_IDLE;
      endcase

      // Outputs are decoded from the next state and registered, so they
      // change on the same edge as the state they describe.
      cmd_next       = cmd_for(state_next);
      hdr_start_next = (state_next == S_HDR_START);
      data_en_next   = (state_next == S_DATA);
      busy_next      = is_session(state_next);
      done_next      = (state_next == S_DONE);
      err_next       = TIMEOUT_EN && (state_next == S_ERR);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         hdr_seen    <= 1'b0;
         word_count  <= '0;
         m_cmd_q     <= CMD_IDLE;
         hdr_start_q <= 1'b0;
         data_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_next;
         m_cmd_q     <= cmd_next;
         hdr_start_q <= hdr_start_next;
         data_en_q   <= data_en_next;
         busy_q      <= busy_next;
         done_q      <= done_next;
         err_q       <= err_next;

         if (state == S_HDR_START) begin
            hdr_seen <= 1'b0;
         end else if (state == S_HDR_RUN && bus.hdr_busy) begin
            hdr_seen <= 1'b1;
         end

         // Wraps silently; the count is held after DONE until the next go.
         if (go_ok) begin
            word_count <= '0;
         end else if (count_en) begin
            word_count <= word_count + 1'b1;
         end
      end
   end

   assign bus.m_cmd        = m_cmd_q;
   assign bus.hdr_start    = hdr_start_q;
   assign bus.data_en      = data_en_q;
   assign bus.session_busy = busy_q;
   assign bus.done         = done_q;
   assign bus.error        = err_q;
   assign bus.word_count   = word_count;

endmodule
